// File: rtl/contador_seq.sv
// contador_seq: command sequencer in front of the 4-bit mode counter.
// Buffers {mode, D, length} commands in a small FIFO and plays each one back
// as a contiguous burst of counter enable cycles with mode/D held stable.
// Optional feature macro: CONTADOR_SEQ_RCO_STOP_EN (rco from the counter ends
// the running burst early). Default build ignores rco.
module contador_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned D_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [D_W-1:0]   cmd_d,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             pause,
  input  logic             rco,
  output logic             enable,
  output logic [1:0]       mode,
  output logic [D_W-1:0]   D,
  output logic             busy,
  output logic             done,
  output logic [7:0]       skip_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Command FIFO storage and pointers
  logic [1:0]       fifo_mode [FIFO_DEPTH];
  logic [D_W-1:0]   fifo_d    [FIFO_DEPTH];
  logic [LEN_W-1:0] fifo_len  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;

  // Sequencer state
  state_t           state_q;
  state_t           state_n;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] rem_n;
  logic             done_q;
  logic             done_n;
  logic             enable_n;
  logic [1:0]       mode_n;
  logic [D_W-1:0]   d_n;
  logic [7:0]       skip_n;
  logic             busy_n;
  logic             ready_n;

  // Combinational helpers
  logic             push_c;
  logic             pop_c;
  logic             take_c;
  logic             skip_inc_c;
  logic             fifo_empty_c;
  logic             last_c;
  logic             rco_stop_c;
  logic [1:0]       head_mode_c;
  logic [D_W-1:0]   head_d_c;
  logic [LEN_W-1:0] head_len_c;

  assign push_c       = cmd_valid & cmd_ready;
  assign fifo_empty_c = (count_q == '0);
  assign head_mode_c  = fifo_mode[rd_ptr_q];
  assign head_d_c     = fifo_d[rd_ptr_q];
  assign head_len_c   = fifo_len[rd_ptr_q];

`ifdef CONTADOR_SEQ_RCO_STOP_EN
  // rco seen during a RUN enable cycle terminates the burst at this edge;
  // done must be visible in that same cycle, so it is folded in directly.
  assign rco_stop_c = (state_q == RUN) & rco;
  assign done       = done_q | rco_stop_c;
`else
  logic unused_rco;
  assign unused_rco = rco;
  assign rco_stop_c = 1'b0;
  assign done       = done_q;
`endif

  // The current RUN cycle is the final enable cycle of the command
  assign last_c = (rem_q == LEN_W'(1)) | rco_stop_c;

  // FIFO payload write (storage needs no reset)
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_mode[wr_ptr_q] <= cmd_mode;
      fifo_d[wr_ptr_q]    <= cmd_d;
      fifo_len[wr_ptr_q]  <= cmd_len;
    end
  end

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    count_n = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ready_n = (count_n != CNT_W'(FIFO_DEPTH));
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_n;
    end
  end

  // Next-state and next-output logic for the playback FSM
  always_comb begin
    state_n    = state_q;
    rem_n      = rem_q;
    enable_n   = 1'b0;
    mode_n     = mode;
    d_n        = D;
    done_n     = 1'b0;
    take_c     = 1'b0;
    pop_c      = 1'b0;
    skip_inc_c = 1'b0;

    case (state_q)
      IDLE: begin
        take_c = !fifo_empty_c && !pause;
      end
      RUN: begin
        if (last_c) begin
          // Burst ends here; chain straight into the next head if allowed
          state_n = IDLE;
          rem_n   = '0;
          take_c  = !fifo_empty_c && !pause;
        end else begin
          rem_n = rem_q - LEN_W'(1);
          if (pause) begin
            state_n = PAUSE;
          end else begin
            enable_n = 1'b1;
            done_n   = (rem_n == LEN_W'(1));
          end
        end
      end
      PAUSE: begin
        if (!pause) begin
          state_n  = RUN;
          enable_n = 1'b1;
          done_n   = (rem_q == LEN_W'(1));
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Head dispatch: zero-length commands are counted and dropped
    if (take_c) begin
      pop_c = 1'b1;
      if (head_len_c == '0) begin
        skip_inc_c = 1'b1;
      end else begin
        state_n  = RUN;
        rem_n    = head_len_c;
        enable_n = 1'b1;
        mode_n   = head_mode_c;
        d_n      = head_d_c;
        done_n   = (head_len_c == LEN_W'(1));
      end
    end
  end

  // Saturating skip count and registered status
  always_comb begin
    skip_n = skip_cnt;
    if (skip_inc_c && (skip_cnt != 8'hFF)) skip_n = skip_cnt + 8'd1;
    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  // FSM state register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      enable    <= 1'b0;
      mode      <= '0;
      D         <= '0;
      done_q    <= 1'b0;
      skip_cnt  <= '0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_n;
      rem_q     <= rem_n;
      enable    <= enable_n;
      mode      <= mode_n;
      D         <= d_n;
      done_q    <= done_n;
      skip_cnt  <= skip_n;
      busy      <= busy_n;
      cmd_ready <= ready_n;
    end
  end

endmodule
